// File: rtl/mem_wb_writeback_if.sv
// MEM/WB stage bus: instruction fields from the memory stage in, register-file write port out.
// master drives the stage inputs, slave is the stage itself.
interface mem_wb_writeback_if #(
  parameter int BITS_SIZE     = 32,
  parameter int REG_ADDR_BITS = 5
);
  logic                     i_stall;
  logic                     i_flush;
  logic                     i_valid;
  logic                     i_reg_write;
  logic [REG_ADDR_BITS-1:0] i_rd;
  logic [1:0]               i_wb_sel;
  logic [BITS_SIZE-1:0]     i_alu_result;
  logic [BITS_SIZE-1:0]     i_mem_data;
  logic [1:0]               i_addr_low;
  logic [1:0]               i_load_size;
  logic                     i_load_unsigned;
  logic [15:0]              i_immediate;
  logic [BITS_SIZE-1:0]     i_pc;
  logic                     o_valid;
  logic                     o_reg_write;
  logic [REG_ADDR_BITS-1:0] o_rd;
  logic [BITS_SIZE-1:0]     o_wb_data;

  modport master (
    output i_stall, i_flush, i_valid, i_reg_write, i_rd, i_wb_sel, i_alu_result,
           i_mem_data, i_addr_low, i_load_size, i_load_unsigned, i_immediate, i_pc,
    input  o_valid, o_reg_write, o_rd, o_wb_data
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_reg_write, i_rd, i_wb_sel, i_alu_result,
           i_mem_data, i_addr_low, i_load_size, i_load_unsigned, i_immediate, i_pc,
    output o_valid, o_reg_write, o_rd, o_wb_data
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// Registered MEM/WB stage: picks ALU, filtered load, LUI or link data and latches it
// with the destination register for the register-file write port and forwarding.
module mem_wb_writeback #(
  parameter int BITS_SIZE     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int LINK_OFFSET   = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  mem_wb_writeback_if.slave bus
);

  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [BITS_SIZE-1:0] load_data;
  logic [BITS_SIZE-1:0] wb_data;
  logic                 sign_fill;

  // Little-endian lane extraction; only the low 32 bits of the memory word carry load data.
  always_comb begin
    lane_byte = bus.i_mem_data[{bus.i_addr_low, 3'b000} +: 8];
    lane_half = bus.i_addr_low[1] ? bus.i_mem_data[31:16] : bus.i_mem_data[15:0];
    sign_fill = 1'b0;
    load_data = '0;
    case (bus.i_load_size)
      2'b00: begin
        sign_fill       = ~bus.i_load_unsigned & lane_byte[7];
        load_data       = {BITS_SIZE{sign_fill}};
        load_data[7:0]  = lane_byte;
      end
      2'b01: begin
        sign_fill       = ~bus.i_load_unsigned & lane_half[15];
        load_data       = {BITS_SIZE{sign_fill}};
        load_data[15:0] = lane_half;
      end
      default: begin
        load_data[31:0] = bus.i_mem_data[31:0];
      end
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (bus.i_wb_sel)
      2'b00:   wb_data = bus.i_alu_result;
      2'b01:   wb_data = load_data;
      2'b10:   wb_data[31:16] = bus.i_immediate;
      default: wb_data = bus.i_pc + BITS_SIZE'(LINK_OFFSET);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_flush) begin
      bus.o_valid     <= 1'b0;
      bus.o_reg_write <= 1'b0;
      bus.o_rd        <= '0;
      bus.o_wb_data   <= '0;
    end else if (!bus.i_stall) begin
      bus.o_valid     <= bus.i_valid;
      // x0 is hardwired to zero, so a write to it is suppressed here rather than in the reg file.
      bus.o_reg_write <= bus.i_valid & bus.i_reg_write & (bus.i_rd != '0);
      bus.o_rd        <= bus.i_rd;
      bus.o_wb_data   <= wb_data;
    end
  end

endmodule
